wave_capture_buffer: RTL and testbench

//  Parametrised, double-buffered, triggered waveform capture memory for the VGA scope path.

---
 rtl/wave_capture_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_wave_capture_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_buffer.sv
// wave_capture_buffer: double-buffered, triggered waveform capture memory.
// A decimated sample stream fills the back bank around a trigger event
// (PRETRIG samples before it). The back bank becomes the front bank on the
// next frame_start, so the display always reads a complete, stable frame.
// Ports:
//   i_clk_sample   single clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_sample_valid one-cycle strobe qualifying i_wave_sample
//   i_wave_sample  unsigned sample
//   i_decim        keep 1 of every (decim+1) valid samples
//   i_trig_mode    00 free-run, 01 rising, 10 falling, 11 single-shot rising
//   i_trig_level   trigger threshold
//   i_arm          rising edge re-arms from IDLE
//   i_freeze       1 holds the front bank (no swaps)
//   i_frame_start  display vsync pulse
//   i_rd_addr      display column
//   o_rd_data      registered front-bank sample for i_rd_addr
//   o_state        0 IDLE, 1 FILL, 2 ARMED, 3 CAPTURE, 4 DONE
//   o_triggered    high from trigger until the swap
//   o_swap_pulse   one-cycle pulse when the banks swap
module wave_capture_buffer #(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned DEPTH    = 1280,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned PRETRIG  = 640,
  parameter int unsigned DECIM_W  = 4
) (
  input  logic                i_clk_sample,
  input  logic                i_reset_n,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_wave_sample,
  input  logic [DECIM_W-1:0]  i_decim,
  input  logic [1:0]          i_trig_mode,
  input  logic [SAMPLE_W-1:0] i_trig_level,
  input  logic                i_arm,
  input  logic                i_freeze,
  input  logic                i_frame_start,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [SAMPLE_W-1:0] o_rd_data,
  output logic [2:0]          o_state,
  output logic                o_triggered,
  output logic                o_swap_pulse
);

  localparam int unsigned PW   = ADDR_W + 1;
  localparam int unsigned MW   = $clog2(2 * DEPTH);
  localparam int unsigned POST = DEPTH - PRETRIG;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] PRE_P   = PW'(PRETRIG);
  localparam logic [PW-1:0] POST_P  = PW'(POST);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  logic [DECIM_W-1:0]  r_dcnt;
  logic [DECIM_W-1:0]  r_dec;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [SAMPLE_W-1:0] r_prev;
  logic [PW-1:0]       r_cnt;
  logic [ADDR_W-1:0]   r_back_start;
  logic [ADDR_W-1:0]   r_front_start;
  logic                r_front_bank;
  logic                r_front_valid;
  logic                r_triggered;
  logic                r_swap_pulse;
  logic                r_arm_q;
  logic [SAMPLE_W-1:0] r_rd_data;
  logic [SAMPLE_W-1:0] r_mem [2*DEPTH];

  logic                w_acc;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_ptr_nxt;
  logic                w_trig;
  logic [PW-1:0]       w_back_start;
  logic [PW-1:0]       w_rd_sum;
  logic [PW-1:0]       w_rd_idx;
  logic [MW-1:0]       w_rd_phys;
  logic [MW-1:0]       w_wr_phys;
  logic                w_rd_ok;

  // Sample acceptance and write enable
  assign w_acc   = i_sample_valid && (r_dcnt == '0);
  assign w_wr_en = w_acc && ((r_state == S_FILL) || (r_state == S_ARMED) ||
                             (r_state == S_CAPTURE));
  assign w_wr_ptr_nxt = (PW'(r_wr_ptr) == DEPTH_P - PW'(1)) ? '0 : r_wr_ptr + ADDR_W'(1);

  // Trigger detection against the previous accepted sample
  always_comb begin
    w_trig = 1'b0;
    case (i_trig_mode)
      2'b00:   w_trig = 1'b1;
      2'b10:   w_trig = (r_prev > i_trig_level) && (i_wave_sample <= i_trig_level);
      default: w_trig = (r_prev < i_trig_level) && (i_wave_sample >= i_trig_level);
    endcase
  end

  // Start of the captured window: trigger pointer minus PRETRIG, modulo DEPTH
  assign w_back_start = (PW'(r_wr_ptr) >= PRE_P) ? PW'(r_wr_ptr) - PRE_P
                                                 : PW'(r_wr_ptr) + DEPTH_P - PRE_P;

  // Read address rotation into the front bank; the back bank is the other half
  assign w_rd_sum  = PW'(r_front_start) + PW'(i_rd_addr);
  assign w_rd_idx  = (w_rd_sum >= DEPTH_P) ? w_rd_sum - DEPTH_P : w_rd_sum;
  assign w_rd_phys = r_front_bank ? MW'(w_rd_idx + DEPTH_P) : MW'(w_rd_idx);
  assign w_wr_phys = r_front_bank ? MW'(r_wr_ptr) : MW'(PW'(r_wr_ptr) + DEPTH_P);
  assign w_rd_ok   = (PW'(i_rd_addr) < DEPTH_P) && r_front_valid;

  // Sample RAM write port (contents survive reset)
  always_ff @(posedge i_clk_sample) begin
    if (w_wr_en) r_mem[w_wr_phys] <= i_wave_sample;
  end

  // Registered read port, masked when out of range or nothing captured yet
  always_ff @(posedge i_clk_sample or negedge i_reset_n) begin
    if (!i_reset_n) r_rd_data <= '0;
    else            r_rd_data <= w_rd_ok ? r_mem[w_rd_phys] : '0;
  end

  // Decimation counter; a new decim value is picked up at each wrap
  always_ff @(posedge i_clk_sample or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dcnt <= '0;
      r_dec  <= '0;
    end else if (i_sample_valid) begin
      if (r_dcnt == '0) begin
        r_dec  <= i_decim;
        r_dcnt <= (i_decim == '0) ? '0 : DECIM_W'(1);
      end else if (r_dcnt >= r_dec) begin
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DECIM_W'(1);
      end
    end
  end

  // Capture control FSM
  always_ff @(posedge i_clk_sample or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_FILL;
      r_wr_ptr      <= '0;
      r_prev        <= '0;
      r_cnt         <= '0;
      r_back_start  <= '0;
      r_front_start <= '0;
      r_front_bank  <= 1'b0;
      r_front_valid <= 1'b0;
      r_triggered   <= 1'b0;
      r_swap_pulse  <= 1'b0;
      r_arm_q       <= 1'b0;
    end else begin
      r_swap_pulse <= 1'b0;
      r_arm_q      <= i_arm;
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_prev   <= i_wave_sample;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_arm && !r_arm_q) r_state <= S_FILL;
        end
        S_FILL: begin
          if (PRETRIG == 0) begin
            // No pre-trigger history: the window starts right here
            r_state      <= S_CAPTURE;
            r_triggered  <= 1'b1;
            r_back_start <= r_wr_ptr;
            r_cnt        <= '0;
          end else if (w_acc) begin
            if (r_cnt == PRE_P - PW'(1)) begin
              r_state <= S_ARMED;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + PW'(1);
            end
          end
        end
        S_ARMED: begin
          if (w_acc && w_trig) begin
            // The triggering sample is the first post-trigger sample
            r_triggered  <= 1'b1;
            r_back_start <= ADDR_W'(w_back_start);
            r_cnt        <= PW'(1);
            r_state      <= (POST == 1) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_acc) begin
            if (r_cnt + PW'(1) == POST_P) r_state <= S_DONE;
            r_cnt <= r_cnt + PW'(1);
          end
        end
        S_DONE: begin
          if (i_frame_start && !i_freeze) begin
            r_front_bank  <= ~r_front_bank;
            r_front_start <= r_back_start;
            r_front_valid <= 1'b1;
            r_swap_pulse  <= 1'b1;
            r_triggered   <= 1'b0;
            r_wr_ptr      <= '0;
            r_cnt         <= '0;
            r_state       <= (i_trig_mode == 2'b11) ? S_IDLE : S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_state      = r_state;
  assign o_triggered  = r_triggered;
  assign o_swap_pulse = r_swap_pulse;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed bench for wave_capture_buffer with DEPTH=16, PRETRIG=4, SAMPLE_W=10.
module tb_wave_capture_buffer;

  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned PRETRIG  = 4;
  localparam int unsigned DECIM_W  = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] wave_sample;
  logic [DECIM_W-1:0]  decim;
  logic [1:0]          trig_mode;
  logic [SAMPLE_W-1:0] trig_level;
  logic                arm;
  logic                freeze;
  logic                frame_start;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic [2:0]          state;
  logic                triggered;
  logic                swap_pulse;

  int n_checks = 0;
  int n_errors = 0;

  wave_capture_buffer #(
    .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .PRETRIG(PRETRIG), .DECIM_W(DECIM_W)
  ) dut (
    .i_clk_sample  (clk),
    .i_reset_n     (reset_n),
    .i_sample_valid(sample_valid),
    .i_wave_sample (wave_sample),
    .i_decim       (decim),
    .i_trig_mode   (trig_mode),
    .i_trig_level  (trig_level),
    .i_arm         (arm),
    .i_freeze      (freeze),
    .i_frame_start (frame_start),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_state       (state),
    .o_triggered   (triggered),
    .o_swap_pulse  (swap_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample, optionally together with a frame_start pulse
  task automatic send(input int v, input bit fs);
    sample_valid = 1'b1;
    wave_sample  = SAMPLE_W'(v);
    frame_start  = fs;
    tick();
    sample_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
  endtask

  task automatic check_rd(input string tag, input int addr, input int exp);
    rd_addr = ADDR_W'(addr);
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    wave_sample  = '0;
    decim        = '0;
    trig_mode    = 2'b01;
    trig_level   = SAMPLE_W'(500);
    arm          = 1'b0;
    freeze       = 1'b0;
    frame_start  = 1'b0;
    rd_addr      = '0;

    // 1. Reset state
    tick();
    tick();
    chk("rst_state", 32'(state), 1);
    chk("rst_swap", 32'(swap_pulse), 0);
    chk("rst_trig", 32'(triggered), 0);
    chk("rst_rd", 32'(rd_data), 0);
    reset_n = 1'b1;
    tick();
    check_rd("rst_rd3", 3, 0);
    check_rd("rst_rd20", 20, 0);

    // 2. Rising trigger at 500 on a ramp (values wrap at 10 bits)
    for (int k = 0; k < 4; k++) send(100 * k, 1'b0);
    chk("t2_armed", 32'(state), 2);
    send(400, 1'b0);
    chk("t2_no_trig", 32'(triggered), 0);
    send(500, 1'b0);
    chk("t2_capture", 32'(state), 3);
    chk("t2_trig", 32'(triggered), 1);
    for (int k = 6; k <= 15; k++) send(100 * k, 1'b0);
    chk("t2_still_cap", 32'(state), 3);
    send(1600, 1'b1);  // frame_start on the cycle DONE is entered is ignored
    chk("t2_done", 32'(state), 4);
    chk("t2_noswap", 32'(swap_pulse), 0);
    tick();
    chk("t2_done_hold", 32'(state), 4);
    frame();
    chk("t2_swap", 32'(swap_pulse), 1);
    chk("t2_fill", 32'(state), 1);
    chk("t2_trig_clr", 32'(triggered), 0);
    tick();
    chk("t2_swap_1cyc", 32'(swap_pulse), 0);
    for (int k = 0; k < 16; k++) begin
      logic [SAMPLE_W-1:0] e;
      e = SAMPLE_W'(100 * (k + 1));
      check_rd($sformatf("t2_rd%0d", k), k, 32'(e));
    end
    check_rd("t2_rd_oob", 16, 0);

    // 3. decim=2: only every third valid sample is stored, level 20
    decim      = DECIM_W'(2);
    trig_level = SAMPLE_W'(20);
    for (int v = 0; v <= 54; v++) send(v, 1'b0);
    chk("t3_done", 32'(state), 4);
    decim = '0;
    send(55, 1'b0);
    send(56, 1'b0);
    chk("t3_done_ign", 32'(state), 4);
    frame();
    chk("t3_swap", 32'(swap_pulse), 1);
    for (int k = 0; k < 16; k++) check_rd($sformatf("t3_rd%0d", k), k, 9 + 3 * k);

    // 4. Free-run with freeze: capture completes but the front bank holds
    trig_mode = 2'b00;
    freeze    = 1'b1;
    for (int k = 0; k < 16; k++) send(700 + k, 1'b0);
    chk("t4_done", 32'(state), 4);
    frame();
    chk("t4_frz_swap1", 32'(swap_pulse), 0);
    tick();
    frame();
    chk("t4_frz_swap2", 32'(swap_pulse), 0);
    chk("t4_frz_state", 32'(state), 4);
    check_rd("t4_frz_rd0", 0, 9);
    check_rd("t4_frz_rd15", 15, 54);
    freeze = 1'b0;
    frame();
    chk("t4_swap", 32'(swap_pulse), 1);
    check_rd("t4_rd0", 0, 700);
    check_rd("t4_rd15", 15, 715);

    // 5. Single-shot: IDLE after the swap, re-armed by an arm pulse
    trig_mode  = 2'b11;
    trig_level = SAMPLE_W'(500);
    for (int k = 0; k < 5; k++) send(400, 1'b0);
    for (int k = 0; k < 12; k++) send(600 + k, 1'b0);
    chk("t5_done", 32'(state), 4);
    frame();
    chk("t5_idle", 32'(state), 0);
    check_rd("t5_rd0", 0, 400);
    check_rd("t5_rd4", 4, 600);
    check_rd("t5_rd15", 15, 611);
    for (int k = 0; k < 5; k++) send(999, 1'b0);
    chk("t5_idle_hold", 32'(state), 0);
    check_rd("t5_idle_rd4", 4, 600);
    arm_pulse();
    chk("t5_rearm", 32'(state), 1);
    for (int k = 1; k <= 5; k++) send(10 * k, 1'b0);
    for (int k = 0; k < 12; k++) send(800 + k, 1'b0);
    chk("t5_done2", 32'(state), 4);
    frame();
    chk("t5_swap2", 32'(swap_pulse), 1);
    chk("t5_idle2", 32'(state), 0);
    check_rd("t5_2_rd0", 0, 20);
    check_rd("t5_2_rd4", 4, 800);
    check_rd("t5_2_rd15", 15, 811);

    // 6. Trigger at wr_ptr=2 so the window wraps (front_start=14)
    trig_mode = 2'b01;
    arm_pulse();
    chk("t6_fill", 32'(state), 1);
    for (int k = 0; k < 4; k++) send(100 + k, 1'b0);
    for (int j = 0; j < 14; j++) send(200 + j, 1'b0);
    send(900, 1'b0);
    chk("t6_capture", 32'(state), 3);
    chk("t6_trig", 32'(triggered), 1);
    for (int k = 1; k < 12; k++) send(900 + k, 1'b0);
    chk("t6_done", 32'(state), 4);
    frame();
    chk("t6_fill2", 32'(state), 1);
    check_rd("t6_rd0", 0, 210);
    check_rd("t6_rd1", 1, 211);
    check_rd("t6_rd3", 3, 213);
    check_rd("t6_rd4", 4, 900);
    check_rd("t6_rd15", 15, 911);

    // Reset in the middle of a capture clears control state and masks the RAM
    for (int k = 1; k <= 5; k++) send(k, 1'b0);
    send(600, 1'b0);
    chk("t6_cap2", 32'(state), 3);
    rd_addr = '0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 1);
    chk("t6_rst_rd", 32'(rd_data), 0);
    chk("t6_rst_trig", 32'(triggered), 0);
    tick();
    reset_n = 1'b1;
    check_rd("t6_post_rst_rd0", 0, 0);
    check_rd("t6_post_rst_rd4", 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
